// File: rtl/rf_wport_arbiter_if.sv
// rf_wport_arbiter_if: bundles the writeback handshakes, the mul/div issue handshake, the
// scoreboard lookups and the register file write port around rf_wport_arbiter.
//
// Modports:
//   master - the surrounding pipeline: drives requests, issue and lookup addresses,
//            observes readies, lookup results and the register file write port.
//   slave  - rf_wport_arbiter itself.
//
// Signals:
//   a_valid/a_rd/a_data -> a_ready          ALU/load writeback request (requester A)
//   b_valid/b_rd/b_data -> b_ready          mul/div writeback request (requester B)
//   iss_valid/iss_rd    -> iss_ready        mul/div issue, reserves iss_rd in the scoreboard
//   rs_q/rt_q           -> rs_busy/rt_busy  scoreboard lookups
//   busy_vec                                full scoreboard (bit 0 always 0)
//   wb_ena/wb_w/wb_rdc/wb_rd                register file write port
interface rf_wport_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;

  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;

  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;

  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic        rs_busy;
  logic        rt_busy;
  logic [31:0] busy_vec;

  logic        wb_ena;
  logic        wb_w;
  logic [4:0]  wb_rdc;
  logic [31:0] wb_rd;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd, rs_q, rt_q,
    input  a_ready, b_ready, iss_ready, rs_busy, rt_busy, busy_vec,
    input  wb_ena, wb_w, wb_rdc, wb_rd
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd, rs_q, rt_q,
    output a_ready, b_ready, iss_ready, rs_busy, rt_busy, busy_vec,
    output wb_ena, wb_w, wb_rdc, wb_rd
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single register file write port between the single-cycle
// ALU/load writeback (A) and the long-latency mul/div writeback (B), and keeps a busy
// scoreboard of registers that B still owes a result for.
//
// A normally wins; once B has been refused STARVE_LIMIT consecutive cycles the arbiter
// favours B for one grant. The winner's rd/data are registered and presented to the
// register file one cycle after the transfer. The scoreboard entry for a B destination is
// cleared on the edge where that write commits; a same-edge issue to that index wins.
//
// Ports:
//   RF_clk  - clock, rising edge
//   RF_rst  - asynchronous reset, active-high
//   bus     - rf_wport_arbiter_if.slave (handshakes, lookups, register file write port)
module rf_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input logic                RF_clk,
  input logic                RF_rst,
  rf_wport_arbiter_if.slave  bus
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StNormal, StFavorB} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        wb_w_q, wb_w_d;
  logic [4:0]  wb_rdc_q, wb_rdc_d;
  logic [31:0] wb_rd_q, wb_rd_d;
  logic        src_q, src_d;
  logic [31:0] busy_q, busy_d;

  logic        a_gnt, b_gnt, iss_gnt;
  logic [31:0] set_mask, clr_mask;

  // Grants: combinational from the registered arbiter state, all forced low in reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!RF_rst) begin
      unique case (state_q)
        StNormal: begin
          a_gnt = bus.a_valid;
          b_gnt = bus.b_valid & ~bus.a_valid;
        end
        StFavorB: begin
          b_gnt = bus.b_valid;
          a_gnt = bus.a_valid & ~bus.b_valid;
        end
        default: ;
      endcase
    end
  end

  // busy_q[0] is held at 0, so an issue to r0 always sees ready.
  assign iss_gnt = bus.iss_valid & ~RF_rst & ~busy_q[bus.iss_rd];

  always_comb begin
    // Starvation counter counts consecutive refused B cycles.
    wait_cnt_d = 4'd0;
    if (bus.b_valid && !b_gnt) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Switch on the edge where the counter reaches the limit, so B wins the very next
    // cycle: worst-case latency STARVE_LIMIT+1 cycles.
    state_d = state_q;
    unique case (state_q)
      StNormal: if (wait_cnt_d >= Limit) state_d = StFavorB;
      StFavorB: if (!bus.b_valid || b_gnt) state_d = StNormal;
      default:  state_d = StNormal;
    endcase

    // Write register stage; rd/data/src hold when nothing transfers.
    wb_w_d   = 1'b0;
    wb_rdc_d = wb_rdc_q;
    wb_rd_d  = wb_rd_q;
    src_d    = src_q;
    if (a_gnt) begin
      wb_w_d   = (bus.a_rd != 5'd0);
      wb_rdc_d = bus.a_rd;
      wb_rd_d  = bus.a_data;
      src_d    = 1'b0;
    end else if (b_gnt) begin
      wb_w_d   = (bus.b_rd != 5'd0);
      wb_rdc_d = bus.b_rd;
      wb_rd_d  = bus.b_data;
      src_d    = 1'b1;
    end

    // Scoreboard: clear applied before set so a same-edge set on the same index wins.
    clr_mask = '0;
    if (wb_w_q && src_q) begin
      clr_mask = 32'd1 << wb_rdc_q;
    end
    set_mask = '0;
    if (iss_gnt && (bus.iss_rd != 5'd0)) begin
      set_mask = 32'd1 << bus.iss_rd;
    end
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  always_ff @(posedge RF_clk or posedge RF_rst) begin
    if (RF_rst) begin
      state_q    <= StNormal;
      wait_cnt_q <= 4'd0;
      wb_w_q     <= 1'b0;
      wb_rdc_q   <= 5'd0;
      wb_rd_q    <= 32'd0;
      src_q      <= 1'b0;
      busy_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wb_w_q     <= wb_w_d;
      wb_rdc_q   <= wb_rdc_d;
      wb_rd_q    <= wb_rd_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.a_ready   = a_gnt;
  assign bus.b_ready   = b_gnt;
  assign bus.iss_ready = ~RF_rst & ~busy_q[bus.iss_rd];
  assign bus.rs_busy   = busy_q[bus.rs_q];
  assign bus.rt_busy   = busy_q[bus.rt_q];
  assign bus.busy_vec  = busy_q;
  assign bus.wb_ena    = 1'b1;
  assign bus.wb_w      = wb_w_q;
  assign bus.wb_rdc    = wb_rdc_q;
  assign bus.wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the arbitration rules,
// the write stage and the scoreboard.
module tb_rf_wport_arbiter;
  localparam int unsigned Limit = 4;

  logic RF_clk = 1'b0;
  logic RF_rst;

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .RF_clk (RF_clk),
    .RF_rst (RF_rst),
    .bus    (bus)
  );

  always #5 RF_clk = ~RF_clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: B is forced through once it has been refused Limit cycles in a row.
  bit [31:0]   m_busy;
  int unsigned m_refused;
  bit          m_wb_w;
  bit [4:0]    m_wb_rdc;
  bit [31:0]   m_wb_rd;
  bit          m_from_b;
  bit          m_a_gnt, m_b_gnt, m_iss_gnt;

  // Values seen at the last sampling point, for directed checks.
  logic        s_a_ready, s_b_ready, s_iss_ready, s_rs_busy, s_wb_w;
  logic [4:0]  s_wb_rdc;
  logic [31:0] s_wb_rd, s_busy_vec;

  task automatic model_reset();
    m_busy    = '0;
    m_refused = 0;
    m_wb_w    = 1'b0;
    m_wb_rdc  = '0;
    m_wb_rd   = '0;
    m_from_b  = 1'b0;
    m_a_gnt   = 1'b0;
    m_b_gnt   = 1'b0;
  endtask

  task automatic idle();
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.iss_valid = 1'b0;
  endtask

  // One clock cycle: sample at the falling edge, advance the model at the rising edge,
  // return 1 time unit after it so the caller can drive the next cycle's inputs.
  task automatic step();
    bit        forced;
    bit [31:0] nb;
    @(negedge RF_clk);
    forced    = bus.b_valid && (m_refused >= Limit);
    m_a_gnt   = bus.a_valid && !forced;
    m_b_gnt   = bus.b_valid && (!bus.a_valid || forced);
    m_iss_gnt = bus.iss_valid && !m_busy[bus.iss_rd];

    s_a_ready   = bus.a_ready;
    s_b_ready   = bus.b_ready;
    s_iss_ready = bus.iss_ready;
    s_rs_busy   = bus.rs_busy;
    s_wb_w      = bus.wb_w;
    s_wb_rdc    = bus.wb_rdc;
    s_wb_rd     = bus.wb_rd;
    s_busy_vec  = bus.busy_vec;

    check_val("a_ready",   32'(bus.a_ready),   32'(m_a_gnt));
    check_val("b_ready",   32'(bus.b_ready),   32'(m_b_gnt));
    check_val("iss_ready", 32'(bus.iss_ready), 32'(!m_busy[bus.iss_rd]));
    check_val("rs_busy",   32'(bus.rs_busy),   32'(m_busy[bus.rs_q]));
    check_val("rt_busy",   32'(bus.rt_busy),   32'(m_busy[bus.rt_q]));
    check_val("busy_vec",  bus.busy_vec,       m_busy);
    check_val("wb_ena",    32'(bus.wb_ena),    32'd1);
    check_val("wb_w",      32'(bus.wb_w),      32'(m_wb_w));
    check_val("wb_rdc",    32'(bus.wb_rdc),    32'(m_wb_rdc));
    check_val("wb_rd",     bus.wb_rd,          m_wb_rd);

    @(posedge RF_clk);
    nb = m_busy;
    if (m_wb_w && m_from_b) nb[m_wb_rdc] = 1'b0;
    if (m_iss_gnt && bus.iss_rd != 5'd0) nb[bus.iss_rd] = 1'b1;
    m_busy = nb;
    m_refused = (bus.b_valid && !m_b_gnt) ? m_refused + 1 : 0;
    if (m_a_gnt) begin
      m_wb_w = (bus.a_rd != 0); m_wb_rdc = bus.a_rd; m_wb_rd = bus.a_data; m_from_b = 1'b0;
    end else if (m_b_gnt) begin
      m_wb_w = (bus.b_rd != 0); m_wb_rdc = bus.b_rd; m_wb_rd = bus.b_data; m_from_b = 1'b1;
    end else begin
      m_wb_w = 1'b0;
    end
    #1;
  endtask

  // Random traffic that honours the hold-until-ready rule.
  task automatic rand_drive();
    if (!bus.a_valid || m_a_gnt) begin
      bus.a_valid = ($urandom_range(0, 3) != 0);
      bus.a_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.a_data  = $urandom;
    end
    if (!bus.b_valid || m_b_gnt) begin
      bus.b_valid = ($urandom_range(0, 1) != 0);
      bus.b_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.b_data  = $urandom;
    end
    bus.iss_valid = ($urandom_range(0, 2) == 0);
    bus.iss_rd    = 5'($urandom);
    bus.rs_q      = 5'($urandom);
    bus.rt_q      = 5'($urandom);
  endtask

  initial begin
    int b_grants[$];
    bus.a_rd = '0; bus.a_data = '0; bus.b_rd = '0; bus.b_data = '0;
    bus.iss_rd = '0; bus.rs_q = '0; bus.rt_q = '0;
    idle();
    model_reset();

    // Reset state, with requests pending to show readies are held low.
    RF_rst = 1'b1;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.iss_valid = 1'b1;
    #2;
    check_val("rst_a_ready",   32'(bus.a_ready),   32'd0);
    check_val("rst_b_ready",   32'(bus.b_ready),   32'd0);
    check_val("rst_iss_ready", 32'(bus.iss_ready), 32'd0);
    check_val("rst_wb_w",      32'(bus.wb_w),      32'd0);
    check_val("rst_wb_ena",    32'(bus.wb_ena),    32'd1);
    check_val("rst_busy_vec",  bus.busy_vec,       32'd0);
    idle();
    @(posedge RF_clk); @(posedge RF_clk); #1;
    RF_rst = 1'b0;

    // A write.
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'hDEADBEEF;
    step();
    check_val("a_write_ready", 32'(s_a_ready), 32'd1);
    idle();
    step();
    check_val("a_write_wb_w",   32'(s_wb_w),   32'd1);
    check_val("a_write_wb_rdc", 32'(s_wb_rdc), 32'd3);
    check_val("a_write_wb_rd",  s_wb_rd,       32'hDEADBEEF);

    // Scoreboard round trip on r9.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; bus.rs_q = 5'd9;
    step();
    check_val("iss9_ready", 32'(s_iss_ready), 32'd1);
    bus.iss_valid = 1'b0;
    step();
    check_val("iss9_busy_next", 32'(s_rs_busy), 32'd1);
    bus.iss_valid = 1'b1;
    step();
    check_val("iss9_second_refused", 32'(s_iss_ready), 32'd0);
    bus.iss_valid = 1'b0;

    // r0 write: completes, no register file write, scoreboard untouched.
    bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'h1234_5678;
    step();
    check_val("r0_ready", 32'(s_a_ready), 32'd1);
    idle();
    step();
    check_val("r0_wb_w",     32'(s_wb_w), 32'd0);
    check_val("r0_busy_vec", s_busy_vec,  32'h0000_0200);

    // B writes r9: transfer in T, busy still set in T+1, clear seen in T+2.
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'hCAFE_F00D;
    step();
    check_val("b9_ready", 32'(s_b_ready), 32'd1);
    idle();
    step();
    check_val("b9_wb_w",      32'(s_wb_w),    32'd1);
    check_val("b9_busy_t1",   32'(s_rs_busy), 32'd1);
    step();
    check_val("b9_busy_t2",   32'(s_rs_busy), 32'd0);

    // Same-edge set and clear on r9: issue lands in the commit cycle of a B write to r9.
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h0BAD_F00D;
    step();
    check_val("same_edge_b_ready", 32'(s_b_ready), 32'd1);
    bus.b_valid = 1'b0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    check_val("same_edge_iss_ready", 32'(s_iss_ready), 32'd1);
    check_val("same_edge_wb_w",      32'(s_wb_w),      32'd1);
    bus.iss_valid = 1'b0;
    step();
    check_val("same_edge_busy9", 32'(s_rs_busy), 32'd1);

    // Starvation: A valid every cycle, B valid from cycle 0.
    bus.a_valid = 1'b1; bus.a_rd = 5'd1;
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h7777_7777;
    for (int c = 0; c < 12; c++) begin
      bus.a_data = 32'(c);
      step();
      if (s_b_ready) begin
        b_grants.push_back(c);
        check_val("starve_a_ready_in_b_cycle", 32'(s_a_ready), 32'd0);
        bus.b_rd = 5'd8; bus.b_data = 32'h8888_8888;
      end
      if (c == 5) check_val("starve_back_to_normal", 32'(s_a_ready), 32'd1);
    end
    while (b_grants.size() < 2) b_grants.push_back(-1);
    check_val("starve_first_b_cycle",  32'(b_grants[0]), 32'd4);
    check_val("starve_second_b_cycle", 32'(b_grants[1]), 32'd9);
    idle();
    step();

    // Reset mid-stream with a pending write and busy[5] set.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    step();
    bus.iss_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h5555_AAAA;
    step();
    check_val("pre_rst_wb_w",  32'(bus.wb_w),        32'd1);
    check_val("pre_rst_busy5", 32'(bus.busy_vec[5]), 32'd1);
    bus.b_valid = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1 RF_rst = 1'b1;
    #1;
    check_val("mid_rst_wb_w",      32'(bus.wb_w),      32'd0);
    check_val("mid_rst_busy_vec",  bus.busy_vec,       32'd0);
    check_val("mid_rst_a_ready",   32'(bus.a_ready),   32'd0);
    check_val("mid_rst_b_ready",   32'(bus.b_ready),   32'd0);
    check_val("mid_rst_iss_ready", 32'(bus.iss_ready), 32'd0);
    check_val("mid_rst_wb_ena",    32'(bus.wb_ena),    32'd1);
    idle();
    model_reset();
    @(posedge RF_clk); @(posedge RF_clk); #1;
    RF_rst = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Arbitrates the single write port of the 32x32 register file between two writeback requesters: A, the single-cycle ALU/load writeback, and B, the long-latency mul/div unit. It also keeps a busy scoreboard of registers owed a result by B, so that the decode stage can stall on read-after-write hazards. The block sits between the writeback sources and the register file write port and drives that port's enable, write strobe, address and data.

## Interface
- STARVE_LIMIT, default 4: consecutive cycles B may wait while A wins before B is forced through. Legal range 1..15.
- RF_clk  in  1  clock; all state updates on the rising edge.
- RF_rst  in  1  asynchronous reset, active-high.
- a_valid  in  1  A has a write pending.
- a_rd  in  5  A destination register.
- a_data  in  32  A write data.
- a_ready  out  1  A write accepted this cycle.
- b_valid  in  1  B has a write pending.
- b_rd  in  5  B destination register.
- b_data  in  32  B write data.
- b_ready  out  1  B write accepted this cycle.
- iss_valid  in  1  a mul/div op is issuing to B this cycle.
- iss_rd  in  5  destination register of the issuing op.
- iss_ready  out  1  issue accepted.
- rs_q  in  5  scoreboard lookup address, port 1.
- rt_q  in  5  scoreboard lookup address, port 2.
- rs_busy  out  1  lookup result for rs_q.
- rt_busy  out  1  lookup result for rt_q.
- busy_vec  out  32  full scoreboard; bit 0 is always 0.
- wb_ena  out  1  register file enable; constant 1 after reset.
- wb_w  out  1  register file write strobe.
- wb_rdc  out  5  register file write address.
- wb_rd  out  32  register file write data.

## Operation
- **Handshake.** Each requester uses valid/ready. Once valid is asserted, the requester holds rd and data stable until ready is seen. A transfer occurs on any cycle where valid and ready are both 1.
- **Arbiter FSM, two states.**
  - NORMAL:
    - A is granted whenever a_valid is 1.
    - B is granted only when b_valid is 1 and a_valid is 0.
  - FAVOR_B:
    - B is granted if b_valid is 1; A waits.
    - If b_valid is 0, A is granted if a_valid is 1.
  - a_ready and b_ready are combinational grants. At most one is 1 in any cycle.
- **wait_cnt (4 bits).**
  - Increments each cycle in which b_valid is 1 and b_ready is 0.
  - Clears to 0 on a B transfer, or when b_valid is 0.
  - When wait_cnt reaches STARVE_LIMIT, the FSM moves NORMAL to FAVOR_B.
  - The FSM moves FAVOR_B to NORMAL on a B transfer, or when b_valid is 0.
- **Write register stage.**
  - A transfer loads wb_rdc and wb_rd with the winner's rd and data, and a 1-bit src tag (0 = A, 1 = B).
  - wb_w is set to 1 if rd is not 0. A transfer to r0 completes its handshake but sets wb_w to 0.
  - A cycle with no transfer sets wb_w to 0; wb_rdc and wb_rd hold their values.
- **Scoreboard (busy[31:1]).**
  - Issue: iss_ready is the negation of busy[iss_rd]. iss_ready is 1 when iss_rd is 0.
  - An issue transfer with iss_rd not 0 sets busy[iss_rd].
  - Clear: on the edge that ends a cycle where wb_w is 1 and src is 1, busy[wb_rdc] is cleared.
  - Simultaneous set and clear on the same index leaves busy at 1 (set wins).
  - A writes never touch the scoreboard.
- **Lookups.** rs_busy and rt_busy are combinational from busy, rs_q and rt_q. Address 0 always returns 0.

## Timing
- Reset values (asynchronous, immediate): busy = 0, wait_cnt = 0, FSM = NORMAL, wb_w = 0, wb_rdc = 0, wb_rd = 0, src = 0, wb_ena = 1.
- While RF_rst is high: a_ready, b_ready and iss_ready are all 0.
- Grant to register file write:
  - Transfer in cycle T.
  - wb_w, wb_rdc and wb_rd are presented in cycle T+1.
  - The register file commits at the end of cycle T+1.
  - busy clears at that same edge, so a lookup in cycle T+2 sees 0.
- Throughput is one write per cycle, with no bubble between back-to-back grants.
- Worst-case B latency with A continuously valid is STARVE_LIMIT+1 cycles from b_valid to b_ready.
- Reset mid-operation:
  - Any pending write in the stage is discarded (wb_w forced to 0).
  - The scoreboard is flushed.
  - Requesters must re-present after reset.

## Test plan
- **Reset.** Assert RF_rst mid-stream while wb_w = 1 and busy[5] = 1. Required: wb_w = 0, busy_vec = 0 and all readies 0 immediately; wb_ena = 1.
- **A write.** a_valid with a_rd = 3, a_data = 0xDEADBEEF. Required: a_ready = 1 the same cycle; next cycle wb_w = 1, wb_rdc = 3, wb_rd = 0xDEADBEEF.
- **Starvation, STARVE_LIMIT = 4.** A valid every cycle; B valid from cycle 0 with b_rd = 7. Required: b_ready = 1 exactly in cycle 4, a_ready = 0 in that cycle, then the FSM returns to NORMAL.
- **r0 write.** a_rd = 0. Required: a_ready = 1, next-cycle wb_w = 0, busy_vec unchanged.
- **Scoreboard round trip.**
  - Issue iss_rd = 9. Required: rs_busy = 1 for rs_q = 9 from the next cycle.
  - A second issue to 9 sees iss_ready = 0.
  - B writes 9, transfer in cycle T. Required: rs_busy = 0 in cycle T+2.
- **Same-edge set and clear.** A new issue to 9 in the cycle where the B write to 9 commits. Required: busy[9] stays 1.
